// File: rtl/tdm_demux_1to8_if.sv
// tdm_demux_1to8_if: serial TDM input and parallel word output bundle for the 1-to-8 demux.
interface tdm_demux_1to8_if;
    logic       din;
    logic       din_valid;
    logic       frame_start;
    logic [7:0] Y;
    logic       y_valid;
    logic       busy;
    logic [2:0] slot;
    logic       frame_err;
    modport master (output din, din_valid, frame_start, input Y, y_valid, busy, slot, frame_err);
    modport slave  (input din, din_valid, frame_start, output Y, y_valid, busy, slot, frame_err);
endinterface

// File: rtl/tdm_demux_1to8.sv
// tdm_demux_1to8: collects 8 serial TDM slots into a parallel word, published only on frame completion.
module tdm_demux_1to8 #(
    parameter bit LSB_FIRST = 1'b1
) (
    input logic              clk,
    input logic              rst,
    tdm_demux_1to8_if.slave  bus
);
    typedef enum logic {IDLE, RECV} state_t;
    state_t     state;
    logic [7:0] shadow;
    logic [7:0] shadow_wr;
    logic [7:0] fresh;
    logic [2:0] lane;
    always_comb begin
        lane         = LSB_FIRST ? bus.slot : ~bus.slot;
        shadow_wr    = shadow;
        shadow_wr[lane] = bus.din;
        fresh        = LSB_FIRST ? {7'b0, bus.din} : {bus.din, 7'b0};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            shadow        <= '0;
            bus.Y         <= '0;
            bus.y_valid   <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.busy      <= 1'b0;
            bus.slot      <= '0;
        end else begin
            bus.y_valid   <= 1'b0;
            bus.frame_err <= 1'b0;
            if (bus.din_valid && bus.frame_start) begin
                // a restart mid-frame drops the partial word and keeps receiving
                bus.frame_err <= (state == RECV);
                shadow        <= fresh;
                bus.slot      <= 3'd1;
                bus.busy      <= 1'b1;
                state         <= RECV;
            end else if (bus.din_valid && state == RECV) begin
                if (bus.slot == 3'd7) begin
                    bus.Y       <= shadow_wr;
                    bus.y_valid <= 1'b1;
                    bus.slot    <= '0;
                    bus.busy    <= 1'b0;
                    state       <= IDLE;
                end else begin
                    shadow   <= shadow_wr;
                    bus.slot <= bus.slot + 3'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_tdm_demux_1to8.sv
// tb_tdm_demux_1to8: directed checks of both lane orders driven with identical serial streams.
module tb_tdm_demux_1to8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;
    tdm_demux_1to8_if i1 ();
    tdm_demux_1to8_if i0 ();
    tdm_demux_1to8 #(.LSB_FIRST(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(i1));
    tdm_demux_1to8 #(.LSB_FIRST(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(i0));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] rev(input logic [7:0] v);
        for (int i = 0; i < 8; i++) rev[i] = v[7-i];
    endfunction

    task automatic drive(input logic b, input logic v, input logic fs);
        i1.din = b; i1.din_valid = v; i1.frame_start = fs;
        i0.din = b; i0.din_valid = v; i0.frame_start = fs;
    endtask

    task automatic send_bit(input logic b, input logic fs);
        drive(b, 1'b1, fs);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic partial(input logic [7:0] v, input int n);
        for (int k = 0; k < n; k++) send_bit(v[k], k == 0);
    endtask

    task automatic send_frame(input logic [7:0] v, input int gap_mod, input logic err_exp, input logic [7:0] y_before);
        for (int k = 0; k < 8; k++) begin
            send_bit(v[k], k == 0);
            if (k == 0) begin
                chk("frame_err1", i1.frame_err, err_exp);
                chk("frame_err0", i0.frame_err, err_exp);
            end
            if (k < 7) begin
                chk("slot", i1.slot, k + 1);
                chk("busy", i1.busy, 1);
                chk("yv_mid", i1.y_valid, 0);
                chk("y_held", i1.Y, y_before);
                for (int g = 0; g < (gap_mod > 0 ? k % gap_mod : 0); g++) begin
                    idle(1);
                    chk("gap_slot", i1.slot, k + 1);
                    chk("gap_yv", i1.y_valid, 0);
                end
            end
        end
        chk("yv1", i1.y_valid, 1);
        chk("yv0", i0.y_valid, 1);
        chk("busy_done", i1.busy, 0);
        chk("slot_done", i1.slot, 0);
        chk("y1", i1.Y, v);
        chk("y0", i0.Y, rev(v));
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0);
        idle(2);
        rst = 1'b0;
        chk("rst_y", i1.Y, 8'h00);
        chk("rst_yv", i1.y_valid, 0);
        chk("rst_busy", i1.busy, 0);
        chk("rst_slot", i1.slot, 0);
        chk("rst_err", i1.frame_err, 0);
        chk("rst_y0", i0.Y, 8'h00);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        idle(1);
        drive(1'b0, 1'b0, 1'b0);
        chk("stray_slot", i1.slot, 0);
        chk("stray_busy", i1.busy, 0);
        send_frame(8'hA5, 0, 1'b0, 8'h00);
        idle(1);
        chk("yv_pulse", i1.y_valid, 0);
        chk("y_hold", i1.Y, 8'hA5);
        send_frame(8'h01, 0, 1'b0, 8'hA5);
        chk("msb_first", i0.Y, 8'h80);
        idle(1);
        send_frame(8'h3C, 4, 1'b0, 8'h01);
        partial(8'hFF, 4);
        send_frame(8'h0F, 0, 1'b1, 8'h3C);
        idle(1);
        chk("err_pulse", i1.frame_err, 0);
        partial(8'hFF, 7);
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        chk("rst7_y", i1.Y, 8'h00);
        chk("rst7_yv", i1.y_valid, 0);
        chk("rst7_slot", i1.slot, 0);
        chk("rst7_busy", i1.busy, 0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        chk("rst_stray", i1.slot, 0);
        send_frame(8'hC3, 0, 1'b0, 8'h00);
        send_frame(8'h12, 0, 1'b0, 8'hC3);
        send_frame(8'h34, 0, 1'b0, 8'h12);
        idle(1);
        chk("b2b_pulse", i1.y_valid, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
